// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, S-box tables, GF(2^8) helpers and FSM state type.
// Rev 1.0
`default_nettype none

package aes_pkg;

   localparam int NB = 128;
   localparam int NR = 10;
   localparam int NK = 4;

   typedef logic [NB-1:0] state_t;
   typedef logic [31:0]   word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYEXP = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } fsm_state_t;

   // Byte 0x00 sits in the top eight bits of each table.
   localparam logic [2047:0] SBOX_BITS = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX_BITS = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b111};
      return SBOX_BITS[idx -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b111};
      return INV_SBOX_BITS[idx -: 8];
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] rc;
      case (i)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/folded_aes_decrypt_if.sv
// folded_aes_decrypt_if: key load, ciphertext input and plaintext output handshakes.
// Rev 1.0
`default_nettype none

interface folded_aes_decrypt_if;
   import aes_pkg::*;

   logic   key_load;
   state_t key;
   logic   key_ready;
   logic   in_valid;
   logic   in_ready;
   state_t cipher_text;
   logic   out_valid;
   logic   out_ready;
   state_t plain_text;
   logic   busy;

   modport master (
      output key_load, key, in_valid, cipher_text, out_ready,
      input  key_ready, in_ready, out_valid, plain_text, busy
   );

   modport slave (
      input  key_load, key, in_valid, cipher_text, out_ready,
      output key_ready, in_ready, out_valid, plain_text, busy
   );

endinterface

`default_nettype wire

// File: rtl/inv_cipher_round.sv
// inv_cipher_round: combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns).
// Rev 1.0
`default_nettype none

module inv_cipher_round
   import aes_pkg::*;
(
   input  state_t i_state,
   input  state_t i_round_key,
   input  logic   i_last_round,
   output state_t o_state
);

   logic [7:0] w_ark [16];
   logic [7:0] w_mix [16];

   generate
      for (genvar c = 0; c < 4; c++) begin : g_col
         for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int c_idx = 4 * c + r;
            // Row r is rotated right by r columns, so the byte comes from column c-r.
            localparam int c_src = 4 * ((c - r + 4) % 4) + r;
            assign w_ark[c_idx] = inv_sbox(i_state[NB-1-8*c_src -: 8])
                                  ^ i_round_key[NB-1-8*c_idx -: 8];
            assign o_state[NB-1-8*c_idx -: 8] = i_last_round ? w_ark[c_idx] : w_mix[c_idx];
         end

         assign w_mix[4*c+0] = gmul(w_ark[4*c+0], 8'h0e) ^ gmul(w_ark[4*c+1], 8'h0b)
                             ^ gmul(w_ark[4*c+2], 8'h0d) ^ gmul(w_ark[4*c+3], 8'h09);
         assign w_mix[4*c+1] = gmul(w_ark[4*c+0], 8'h09) ^ gmul(w_ark[4*c+1], 8'h0e)
                             ^ gmul(w_ark[4*c+2], 8'h0b) ^ gmul(w_ark[4*c+3], 8'h0d);
         assign w_mix[4*c+2] = gmul(w_ark[4*c+0], 8'h0d) ^ gmul(w_ark[4*c+1], 8'h09)
                             ^ gmul(w_ark[4*c+2], 8'h0e) ^ gmul(w_ark[4*c+3], 8'h0b);
         assign w_mix[4*c+3] = gmul(w_ark[4*c+0], 8'h0b) ^ gmul(w_ark[4*c+1], 8'h0d)
                             ^ gmul(w_ark[4*c+2], 8'h09) ^ gmul(w_ark[4*c+3], 8'h0e);
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/folded_aes_decrypt.sv
// folded_aes_decrypt: iterative AES-128 decryptor, one round per cycle with on-the-fly inverse key schedule.
// Rev 1.0
`default_nettype none

module folded_aes_decrypt (
   input logic                 clk,
   input logic                 reset,
   folded_aes_decrypt_if.slave bus
);
   import aes_pkg::*;

   localparam logic [3:0] c_last_round   = 4'(NR);
   localparam logic [3:0] c_first_middle = 4'(NR - 1);

   fsm_state_t r_fsm;
   logic [3:0] r_count;
   state_t     r_last_key;
   state_t     r_rk_cur;
   state_t     r_state;
   state_t     r_plain_text;
   logic       r_key_ready;
   logic       r_out_valid;
   logic       r_busy;

   state_t     w_fwd_key;
   state_t     w_inv_src;
   state_t     w_inv_key;
   state_t     w_round_out;
   logic [3:0] w_inv_rcon_idx;

   function automatic state_t fwd_step(input state_t k, input logic [7:0] rc);
      word_t t, n0, n1, n2, n3;
      t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
      n0 = k[127:96] ^ t;
      n1 = k[95:64]  ^ n0;
      n2 = k[63:32]  ^ n1;
      n3 = k[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one forward step: the previous key's last three words fall out of
   // adjacent XORs, and its first word needs the same g() as the forward step.
   function automatic state_t inv_step(input state_t k, input logic [7:0] rc);
      word_t p0, p1, p2, p3;
      p3 = k[31:0]  ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
      return {p0, p1, p2, p3};
   endfunction

   assign w_fwd_key      = fwd_step(r_rk_cur, rcon(r_count));
   assign w_inv_src      = (r_fsm == IDLE) ? r_last_key : r_rk_cur;
   assign w_inv_rcon_idx = (r_fsm == IDLE) ? c_last_round : r_count;
   assign w_inv_key      = inv_step(w_inv_src, rcon(w_inv_rcon_idx));

   inv_cipher_round u_round (
      .i_state      (r_state),
      .i_round_key  (r_rk_cur),
      .i_last_round (r_count == 4'd0),
      .o_state      (w_round_out)
   );

   assign bus.key_ready  = r_key_ready;
   assign bus.in_ready   = r_key_ready && (r_fsm == IDLE);
   assign bus.out_valid  = r_out_valid;
   assign bus.plain_text = r_plain_text;
   assign bus.busy       = r_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm        <= IDLE;
         r_count      <= 4'd0;
         r_last_key   <= '0;
         r_rk_cur     <= '0;
         r_state      <= '0;
         r_plain_text <= '0;
         r_key_ready  <= 1'b0;
         r_out_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: begin
               // A key load takes priority over a pending block.
               if (bus.key_load) begin
                  r_rk_cur    <= bus.key;
                  r_count     <= 4'd1;
                  r_key_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_fsm       <= KEYEXP;
               end else if (bus.in_valid && r_key_ready) begin
                  r_state  <= bus.cipher_text ^ r_last_key;
                  r_rk_cur <= w_inv_key;
                  r_count  <= c_first_middle;
                  r_busy   <= 1'b1;
                  r_fsm    <= ROUND;
               end
            end
            KEYEXP: begin
               r_rk_cur <= w_fwd_key;
               r_count  <= r_count + 4'd1;
               if (r_count == c_last_round) begin
                  r_last_key  <= w_fwd_key;
                  r_key_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_fsm       <= IDLE;
               end
            end
            ROUND: begin
               if (r_count == 4'd0) begin
                  r_plain_text <= w_round_out;
                  r_out_valid  <= 1'b1;
                  r_fsm        <= DONE;
               end else begin
                  r_state  <= w_round_out;
                  r_rk_cur <= w_inv_key;
                  r_count  <= r_count - 4'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_fsm       <= IDLE;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_folded_aes_decrypt.sv
// tb_folded_aes_decrypt: directed FIPS-197 vectors, timing, backpressure and reset scenarios.
// Rev 1.0
`default_nettype none

module tb_folded_aes_decrypt;

   localparam logic [127:0] c_key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] c_ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] c_pt_c1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] c_rk10_c1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] c_key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] c_ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] c_pt_b   = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   folded_aes_decrypt_if bus ();

   folded_aes_decrypt dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [127:0] k, output int lat);
      bus.key      = k;
      bus.key_load = 1'b1;
      tick();
      bus.key_load = 1'b0;
      lat = 0;
      while (bus.key_ready !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic start_block(input logic [127:0] ct);
      bus.cipher_text = ct;
      bus.in_valid    = 1'b1;
      tick();
      bus.in_valid    = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (bus.key_ready !== 1'b0) begin failures++; $display("FAIL reset_key_ready: got %b want 0", bus.key_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++;
      if (bus.plain_text !== 128'h0) begin failures++; $display("FAIL reset_plain_text: got %h want 0", bus.plain_text); end
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_busy_in_ready: got busy=%b in_ready=%b want 0/0", bus.busy, bus.in_ready);
      end
   endtask

   task automatic test_key_expansion();
      int lat;
      bus.key      = c_key_c1;
      bus.key_load = 1'b1;
      tick();
      bus.key_load = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL keyexp_busy: got busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
      end
      lat = 0;
      while (bus.key_ready !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 10) begin failures++; $display("FAIL keyexp_latency: got %0d want 10", lat); end
      checks++;
      if (dut.r_last_key !== c_rk10_c1) begin failures++; $display("FAIL keyexp_last_key: got %h want %h", dut.r_last_key, c_rk10_c1); end
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL keyexp_done: got busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready);
      end
   endtask

   task automatic test_decrypt_c1();
      int lat;
      start_block(c_ct_c1);
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL c1_busy_after_accept: got busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
      end
      wait_out(lat);
      checks++;
      if (lat != 10) begin failures++; $display("FAIL c1_latency: got %0d want 10", lat); end
      checks++;
      if (bus.plain_text !== c_pt_c1) begin failures++; $display("FAIL c1_plain_text: got %h want %h", bus.plain_text, c_pt_c1); end
      release_out();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL c1_release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_decrypt_fips_b();
      int lat;
      load_key(c_key_b, lat);
      checks++;
      if (lat != 10) begin failures++; $display("FAIL b_key_latency: got %0d want 10", lat); end
      start_block(c_ct_b);
      wait_out(lat);
      checks++;
      if (lat != 10) begin failures++; $display("FAIL b_latency: got %0d want 10", lat); end
      checks++;
      if (bus.plain_text !== c_pt_b) begin failures++; $display("FAIL b_plain_text: got %h want %h", bus.plain_text, c_pt_b); end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      start_block(c_ct_b);
      wait_out(lat);
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (bus.plain_text !== c_pt_b || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_hold: cycle %0d got pt=%h ov=%b ir=%b want %h/1/0",
                     i, bus.plain_text, bus.out_valid, bus.in_ready, c_pt_b);
         end
      end
      release_out();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL backpressure_release: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      int             lat;
      int             accepts;
      int             outs;
      int             out_cycle [2];
      logic [127:0]   out_data  [2];
      load_key(c_key_c1, lat);
      accepts         = 0;
      outs            = 0;
      bus.out_ready   = 1'b1;
      bus.cipher_text = c_ct_c1;
      bus.in_valid    = 1'b1;
      for (int c = 0; c < 60 && outs < 2; c++) begin
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) accepts++;
         tick();
         if (accepts == 2) bus.in_valid = 1'b0;
         if (bus.out_valid === 1'b1) begin
            out_cycle[outs] = c;
            out_data[outs]  = bus.plain_text;
            outs++;
         end
      end
      bus.in_valid  = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      checks++;
      if (outs != 2) begin
         failures++; $display("FAIL b2b_count: got %0d outputs want 2", outs);
      end else begin
         checks++;
         if (out_data[0] !== c_pt_c1 || out_data[1] !== c_pt_c1) begin
            failures++; $display("FAIL b2b_data: got %h %h want %h", out_data[0], out_data[1], c_pt_c1);
         end
         checks++;
         if (out_cycle[1] - out_cycle[0] != 12) begin
            failures++; $display("FAIL b2b_period: got %0d want 12", out_cycle[1] - out_cycle[0]);
         end
      end
   endtask

   task automatic test_reset_mid_round();
      start_block(c_ct_c1);
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (dut.r_count !== 4'd5) begin failures++; $display("FAIL mid_round_count: got %0d want 5", dut.r_count); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.key_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_flags: got kr=%b ov=%b busy=%b ir=%b want 0/0/0/0",
                  bus.key_ready, bus.out_valid, bus.busy, bus.in_ready);
      end
      checks++;
      if (bus.plain_text !== 128'h0) begin failures++; $display("FAIL mid_reset_plain_text: got %h want 0", bus.plain_text); end
      bus.cipher_text = c_ct_c1;
      bus.in_valid    = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL no_key_ignore: cycle %0d got busy=%b ov=%b want 0/0", i, bus.busy, bus.out_valid);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_key_load_collision();
      int lat;
      load_key(c_key_c1, lat);
      bus.key          = c_key_b;
      bus.key_load     = 1'b1;
      bus.cipher_text  = c_ct_b;
      bus.in_valid     = 1'b1;
      tick();
      bus.key_load     = 1'b0;
      bus.in_valid     = 1'b0;
      checks++;
      if (bus.key_ready !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL collision_state: got kr=%b ir=%b busy=%b want 0/0/1", bus.key_ready, bus.in_ready, bus.busy);
      end
      lat = 0;
      while (bus.key_ready !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 10 || bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL collision_keyexp: got latency=%0d ov=%b want 10/0", lat, bus.out_valid);
      end
      start_block(c_ct_b);
      wait_out(lat);
      checks++;
      if (bus.plain_text !== c_pt_b) begin failures++; $display("FAIL collision_new_key: got %h want %h", bus.plain_text, c_pt_b); end
      release_out();
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      reset           = 1'b1;
      bus.key_load    = 1'b0;
      bus.key         = '0;
      bus.in_valid    = 1'b0;
      bus.cipher_text = '0;
      bus.out_ready   = 1'b0;

      test_reset();
      test_key_expansion();
      test_decrypt_c1();
      test_decrypt_fips_b();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_round();
      test_key_load_collision();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
